// File: rtl/aqu2ahb_master_pkg.sv
// Shared AHB-Lite encodings, FSM state type and SEL-decode result for the
// Aqu-bus to AHB-Lite master bridge.
package aqu2ahb_master_pkg;

  localparam logic [1:0] AHB_IDLE   = 2'b00;
  localparam logic [1:0] AHB_NONSEQ = 2'b10;

  localparam logic AHB_OKAY  = 1'b0;
  localparam logic AHB_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [2:0] {
    a2h_IDLE   = 3'd0,
    a2h_ADDR   = 3'd1,
    a2h_DATA   = 3'd2,
    a2h_DONE   = 3'd3,
    a2h_ERRACK = 3'd4
  } aqu2ahb_st;

  // Result of decoding a big-endian SEL pattern into an AHB transfer shape.
  typedef struct packed {
    logic       legal;
    logic [2:0] hsize;
    logic [1:0] lane;
  } sel_dec_t;

endpackage

// File: rtl/aqu2ahb_master_if.sv
// Bus interfaces for the bridge: Aqu-bus request/response side and AHB-Lite side.
//
// Aqu handshake: the initiator raises aq_stb with aq_adr/aq_we/aq_sel/aq_wdata
// stable and holds it until it sees the one-cycle aq_ack pulse; aq_err and
// aq_rdata are meaningful only in the aq_ack cycle (aq_rdata stays held after).
interface aqu_if;
  logic        aq_stb;
  logic [31:0] aq_adr;
  logic        aq_we;
  logic [3:0]  aq_sel;
  logic [31:0] aq_wdata;
  logic        aq_ack;
  logic        aq_err;
  logic [31:0] aq_rdata;

  modport master (
    output aq_stb, aq_adr, aq_we, aq_sel, aq_wdata,
    input  aq_ack, aq_err, aq_rdata
  );

  modport slave (
    input  aq_stb, aq_adr, aq_we, aq_sel, aq_wdata,
    output aq_ack, aq_err, aq_rdata
  );
endinterface

interface ahb_if;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/aqu2ahb_master_aqu_sel_dec.sv
// Combinational SEL decoder: big-endian byte-lane mask -> {legal, hsize, haddr[1:0]}.
// Illegal patterns decode as a word at lane 0 so the caller can fall back to a word access.
module aqu_sel_dec
  import aqu2ahb_master_pkg::*;
(
  input  logic [3:0] sel,
  output sel_dec_t   dec
);

  always_comb begin
    dec = '{legal: 1'b0, hsize: HSIZE_WORD, lane: 2'b00};
    case (sel)
      4'b1111: dec = '{legal: 1'b1, hsize: HSIZE_WORD, lane: 2'b00};
      4'b1100: dec = '{legal: 1'b1, hsize: HSIZE_HALF, lane: 2'b00};
      4'b0011: dec = '{legal: 1'b1, hsize: HSIZE_HALF, lane: 2'b10};
      4'b1000: dec = '{legal: 1'b1, hsize: HSIZE_BYTE, lane: 2'b00};
      4'b0100: dec = '{legal: 1'b1, hsize: HSIZE_BYTE, lane: 2'b01};
      4'b0010: dec = '{legal: 1'b1, hsize: HSIZE_BYTE, lane: 2'b10};
      4'b0001: dec = '{legal: 1'b1, hsize: HSIZE_BYTE, lane: 2'b11};
      default: ;
    endcase
  end

endmodule

// File: rtl/aqu2ahb_master.sv
// Aqu-bus initiator to AHB-Lite master bridge: single NONSEQ transfers, one outstanding.
// Optional posted writes enabled by defining AQU2AHB_POSTED_WR_EN.
module aqu2ahb_master
  import aqu2ahb_master_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL   = 4'b0011,
  parameter bit         BAD_SEL_ERR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  aqu_if.slave       aq,
  ahb_if.master      ahb,
  output logic       wr_err,
  input  logic       wr_err_clr,
  output aqu2ahb_st  dbg_state
);

  aqu2ahb_st   state, state_nxt;
  sel_dec_t    dec;

  logic [31:0] haddr_q;
  logic [1:0]  htrans_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [3:0]  hprot_q;
  logic [31:0] hwdata_q;
  logic [31:0] wdata_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        ld_req;
  logic        ld_rdata;
  logic        ack_d;
  logic        err_d;
  logic        set_wr_err;

  aqu_sel_dec u_sel_dec (
    .sel (aq.aq_sel),
    .dec (dec)
  );

`ifdef AQU2AHB_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
  logic wr_err_q;

  // A fresh error outranks a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_err_q <= 1'b0;
    end else if (set_wr_err) begin
      wr_err_q <= 1'b1;
    end else if (wr_err_clr) begin
      wr_err_q <= 1'b0;
    end
  end

  assign wr_err = wr_err_q;

  logic unused_adr_lo;
  assign unused_adr_lo = ^aq.aq_adr[1:0];
`else
  localparam bit POSTED = 1'b0;

  assign wr_err = 1'b0;

  logic unused_sigs;
  assign unused_sigs = ^{aq.aq_adr[1:0], wr_err_clr, set_wr_err};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= a2h_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ld_req     = 1'b0;
    ld_rdata   = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    set_wr_err = 1'b0;
    case (state)
      a2h_IDLE: begin
        if (aq.aq_stb) begin
          if (dec.legal || !BAD_SEL_ERR) begin
            ld_req    = 1'b1;
            state_nxt = a2h_ADDR;
            ack_d     = POSTED && aq.aq_we;
          end else begin
            ack_d     = 1'b1;
            err_d     = 1'b1;
            state_nxt = a2h_ERRACK;
          end
        end
      end
      a2h_ADDR: begin
        if (ahb.hready) state_nxt = a2h_DATA;
      end
      a2h_DATA: begin
        // An ERROR response with hready low is only the first of its two cycles.
        if (ahb.hready) begin
          if (POSTED && hwrite_q) begin
            set_wr_err = (ahb.hresp == AHB_ERROR);
            state_nxt  = a2h_IDLE;
          end else begin
            ld_rdata  = !hwrite_q;
            ack_d     = 1'b1;
            err_d     = (ahb.hresp == AHB_ERROR);
            state_nxt = a2h_DONE;
          end
        end
      end
      a2h_DONE:   state_nxt = a2h_IDLE;
      a2h_ERRACK: state_nxt = a2h_IDLE;
      default:    state_nxt = a2h_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      haddr_q  <= '0;
      htrans_q <= AHB_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hprot_q  <= '0;
      hwdata_q <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      htrans_q <= (state_nxt == a2h_ADDR) ? AHB_NONSEQ : AHB_IDLE;
      hprot_q  <= HPROT_VAL;
      ack_q    <= ack_d;
      err_q    <= err_d;
      if (ld_req) begin
        haddr_q  <= {aq.aq_adr[31:2], dec.lane};
        hsize_q  <= dec.hsize;
        hwrite_q <= aq.aq_we;
        wdata_q  <= aq.aq_wdata;
      end
      if (state == a2h_ADDR && ahb.hready) hwdata_q <= wdata_q;
      if (ld_rdata) rdata_q <= ahb.hrdata;
    end
  end

  assign ahb.haddr  = haddr_q;
  assign ahb.htrans = htrans_q;
  assign ahb.hwrite = hwrite_q;
  assign ahb.hsize  = hsize_q;
  assign ahb.hburst = HBURST_SINGLE;
  assign ahb.hprot  = hprot_q;
  assign ahb.hwdata = hwdata_q;

  assign aq.aq_ack   = ack_q;
  assign aq.aq_err   = err_q;
  assign aq.aq_rdata = rdata_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_aqu2ahb_master.sv
// Bench for aqu2ahb_master: directed Aqu requests against a small AHB responder,
// with a queue-based scoreboard on the ack/err/rdata response.
module tb_aqu2ahb_master;
  import aqu2ahb_master_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      wr_err;
  logic      wr_err_clr = 1'b0;
  aqu2ahb_st dbg_state;

  aqu_if aq();
  ahb_if ahb();

  aqu2ahb_master #(.HPROT_VAL(4'b0011), .BAD_SEL_ERR(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .aq         (aq),
    .ahb        (ahb),
    .wr_err     (wr_err),
    .wr_err_clr (wr_err_clr),
    .dbg_state  (dbg_state)
  );

`ifdef AQU2AHB_POSTED_WR_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // clock / reset
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic [31:0] last_rdata = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // scoreboard monitor: every ack pops one expected {err, rdata}
  always @(negedge clk) begin
    if (rst_n && aq.aq_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack got err=%0b rdata=%h exp no ack", aq.aq_err, aq.aq_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("ack_resp", {31'd0, aq.aq_err, aq.aq_rdata}, {31'd0, mon_exp});
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"}, {19'd0, ahb.haddr, ahb.htrans, ahb.hwrite, ahb.hsize, ahb.hburst, ahb.hprot}, 64'd0);
    chk({tag, "_hwdata"}, {32'd0, ahb.hwdata}, 64'd0);
    chk({tag, "_rdata"}, {32'd0, aq.aq_rdata}, 64'd0);
    chk({tag, "_flags"}, {58'd0, aq.aq_ack, aq.aq_err, wr_err, dbg_state}, 64'd0);
  endtask

  // driver: one Aqu request plus the AHB responder for its transfer
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int aw, input int dw, input bit err_resp, input bit drop_early,
                      input logic [31:0] exp_haddr, input logic [2:0] exp_hsize,
                      input bit illegal);
    int          n = 0;
    int          aw_left = aw;
    int          dw_left = dw;
    int          exp_ack_n;
    int          ack_n_got = -1;
    int          nonseq_xfers = 0;
    bit          ack_seen = 0, done = 0;
    bit          prev_ns = 0, prev_hr = 1, prev_data = 0, data_now;
    bit          err_first_done = 0, ctrl_bad = 0, ns_seen = 0;
    logic [31:0] haddr_seen = '0, hwdata_seen = '0;
    logic [2:0]  hsize_seen = '0;

    if (illegal) begin
      exp_ack_n = 1;
      exp_q.push_back({1'b1, last_rdata});
    end else if (POSTED && we) begin
      exp_ack_n = 1;
      exp_q.push_back({1'b0, last_rdata});
    end else begin
      exp_ack_n = 3 + aw + dw + (err_resp ? 1 : 0);
      if (!we) last_rdata = rdata;
      exp_q.push_back({err_resp, last_rdata});
    end

    aq.aq_stb   = 1'b1;
    aq.aq_adr   = adr;
    aq.aq_we    = we;
    aq.aq_sel   = sel;
    aq.aq_wdata = wdata;
    ahb.hready  = 1'b1;
    ahb.hresp   = AHB_OKAY;
    ahb.hrdata  = rdata;

    while (!done && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (drop_early && n == 1) aq.aq_stb = 1'b0;
      data_now = (prev_ns && prev_hr) || (prev_data && !prev_hr);
      if (aq.aq_ack && !ack_seen) begin
        ack_seen  = 1;
        ack_n_got = n;
        aq.aq_stb = 1'b0;
      end
      if (ahb.htrans == AHB_NONSEQ) begin
        if (!ns_seen) begin
          haddr_seen = ahb.haddr;
          hsize_seen = ahb.hsize;
          ns_seen    = 1;
        end
        if (ahb.haddr !== exp_haddr || ahb.hsize !== exp_hsize || ahb.hwrite !== we ||
            ahb.hburst !== HBURST_SINGLE || ahb.hprot !== 4'b0011)
          ctrl_bad = 1;
        ahb.hready = (aw_left == 0);
        if (aw_left > 0) aw_left--;
        if (ahb.hready) nonseq_xfers++;
      end else if (data_now) begin
        hwdata_seen = ahb.hwdata;
        if (dw_left > 0) begin
          ahb.hready = 1'b0;
          ahb.hresp  = AHB_OKAY;
          dw_left--;
        end else if (err_resp && !err_first_done) begin
          ahb.hready     = 1'b0;
          ahb.hresp      = AHB_ERROR;
          err_first_done = 1;
        end else begin
          ahb.hready = 1'b1;
          ahb.hresp  = err_resp ? AHB_ERROR : AHB_OKAY;
        end
      end else begin
        ahb.hready = 1'b1;
        ahb.hresp  = AHB_OKAY;
      end
      prev_ns   = (ahb.htrans == AHB_NONSEQ);
      prev_hr   = ahb.hready;
      prev_data = data_now;
      if (ack_seen && !prev_ns && !data_now) done = 1;
    end

    if (!ack_seen) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout adr=%h got no ack exp ack at cycle %0d", adr, exp_ack_n);
    end
    chk("ack_cycle", 64'(ack_n_got), 64'(exp_ack_n));
    chk("nonseq_xfers", 64'(nonseq_xfers), illegal ? 64'd0 : 64'd1);
    if (!illegal) begin
      chk("haddr", {32'd0, haddr_seen}, {32'd0, exp_haddr});
      chk("hsize", {61'd0, hsize_seen}, {61'd0, exp_hsize});
      chk("ctrl_stable", {63'd0, ctrl_bad}, 64'd0);
      if (we) chk("hwdata", {32'd0, hwdata_seen}, {32'd0, wdata});
    end

    aq.aq_stb  = 1'b0;
    ahb.hready = 1'b1;
    ahb.hresp  = AHB_OKAY;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got no finish exp finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    aq.aq_stb   = 1'b0;
    aq.aq_adr   = '0;
    aq.aq_we    = 1'b0;
    aq.aq_sel   = '0;
    aq.aq_wdata = '0;
    ahb.hready  = 1'b1;
    ahb.hresp   = AHB_OKAY;
    ahb.hrdata  = '0;

    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_hprot", {60'd0, ahb.hprot}, 64'h3);
    chk("post_reset_idle", {61'd0, dbg_state}, {61'd0, a2h_IDLE});

    xfer(1'b0, 32'h0000_1000, 4'b1111, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0000_1000, HSIZE_WORD, 0);
    xfer(1'b1, 32'h0000_2003, 4'b0010, 32'h0000_AB00, 32'h0, 0, 0, 0, 0, 32'h0000_2002, HSIZE_BYTE, 0);
    xfer(1'b0, 32'h0000_3004, 4'b1100, 32'h0, 32'h1234_5678, 2, 3, 0, 0, 32'h0000_3004, HSIZE_HALF, 0);
    xfer(1'b0, 32'h0000_4001, 4'b0011, 32'h0, 32'hA5A5_0F0F, 0, 0, 1, 0, 32'h0000_4002, HSIZE_HALF, 0);
    xfer(1'b0, 32'h0000_5000, 4'b0001, 32'h0, 32'h0000_00C3, 0, 0, 0, 0, 32'h0000_5003, HSIZE_BYTE, 0);
    xfer(1'b0, 32'h0000_6000, 4'b0110, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, HSIZE_WORD, 1);
    xfer(1'b1, 32'h0000_6100, 4'b0000, 32'h1111_1111, 32'h0, 0, 0, 0, 0, 32'h0, HSIZE_WORD, 1);
    xfer(1'b0, 32'h0000_7008, 4'b1000, 32'h0, 32'h7766_5544, 1, 0, 0, 1, 32'h0000_7008, HSIZE_BYTE, 0);

    // error write with clear held high: a new error must still set the flag
    wr_err_clr = 1'b1;
    xfer(1'b1, 32'h0000_8000, 4'b0100, 32'h00CD_0000, 32'h0, 0, 1, 1, 0, 32'h0000_8001, HSIZE_BYTE, 0);
    chk("wr_err_set", {63'd0, wr_err}, {63'd0, POSTED});
    wr_err_clr = 1'b0;
    @(negedge clk);
    chk("wr_err_sticky", {63'd0, wr_err}, {63'd0, POSTED});
    wr_err_clr = 1'b1;
    @(negedge clk);
    wr_err_clr = 1'b0;
    chk("wr_err_clr", {63'd0, wr_err}, 64'd0);

    xfer(1'b1, 32'h0000_9000, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 1, 0, 0, 32'h0000_9000, HSIZE_WORD, 0);

    // reset while the data phase is stalled
    aq.aq_stb   = 1'b1;
    aq.aq_adr   = 32'h0000_B000;
    aq.aq_we    = 1'b0;
    aq.aq_sel   = 4'b1111;
    ahb.hready  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ahb.hready  = 1'b0;
    @(negedge clk);
    chk("in_data_before_reset", {61'd0, dbg_state}, {61'd0, a2h_DATA});
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    aq.aq_stb  = 1'b0;
    ahb.hready = 1'b1;
    rst_n      = 1'b1;
    last_rdata = '0;
    repeat (2) @(negedge clk);

    xfer(1'b0, 32'h0000_A000, 4'b1111, 32'h0, 32'h0BAD_F00D, 0, 0, 0, 0, 32'h0000_A000, HSIZE_WORD, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
